// File: rtl/pong_game_engine.sv
// pong_game_engine: two-player pong core with paddles, ball physics, scoring,
// game FSM and a registered pixel colour path. Game state moves on tick only.
module pong_game_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int P1_X        = 32,
    parameter int P2_X        = 600,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_HALF = 20,
    parameter int PADDLE_STEP = 2,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_STEP   = 1,
    parameter int SERVE_TICKS = 64,
    parameter int WIN_SCORE   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       in_display,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state
);

    localparam logic [1:0] QI     = 2'b00;
    localparam logic [1:0] QSERVE = 2'b01;
    localparam logic [1:0] QPLAY  = 2'b10;
    localparam logic [1:0] QDONE  = 2'b11;

    localparam logic [10:0] CX      = 11'(H_ACTIVE / 2);
    localparam logic [10:0] CY      = 11'(V_ACTIVE / 2);
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] PY_MIN  = 11'(PADDLE_HALF);
    localparam logic [10:0] PY_MAX  = 11'(V_ACTIVE - 1 - PADDLE_HALF);
    localparam logic [10:0] P_HALF  = 11'(PADDLE_HALF);
    localparam logic [10:0] P_STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] B_STEP  = 11'(BALL_STEP);
    localparam logic [10:0] P1_L    = 11'(P1_X);
    localparam logic [10:0] P1_R    = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_L    = 11'(P2_X);
    localparam logic [10:0] P2_R    = 11'(P2_X + PADDLE_W);
    localparam logic [10:0] P2_FACE = 11'(P2_X - BALL_SIZE);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

    localparam int CW = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);

    logic [1:0]    state_q, state_d;
    logic [9:0]    p1_y_q, p1_y_d;
    logic [9:0]    p2_y_q, p2_y_d;
    logic [9:0]    ball_x_q, ball_x_d;
    logic [9:0]    ball_y_q, ball_y_d;
    logic          dx_neg_q, dx_neg_d;
    logic          dy_neg_q, dy_neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    s1_q, s1_d;
    logic [3:0]    s2_q, s2_d;
    logic          vga_r_q, vga_g_q, vga_b_q;

    logic paddles_en, play_en, net_en;
    logic miss_l, miss_r, miss, win, serve_done;
    logic ov1, ov2, hit1, hit2;
    logic on_p1, on_p2, on_ball, on_net;

    logic [10:0] bx, by, p1y, p2y, cx, cy;

    assign bx  = {1'b0, ball_x_q};
    assign by  = {1'b0, ball_y_q};
    assign p1y = {1'b0, p1_y_q};
    assign p2y = {1'b0, p2_y_q};
    assign cx  = {1'b0, counter_x};
    assign cy  = {1'b0, counter_y};

    // Clamps are tested before stepping so the 10-bit value never wraps.
    function automatic logic [9:0] paddle_next(
        input logic [9:0] y,
        input logic       up,
        input logic       dn
    );
        logic [10:0] y11;
        y11 = {1'b0, y};
        if (up && !dn) begin
            return (y11 <= PY_MIN + P_STEP) ? PY_MIN[9:0] : y - P_STEP[9:0];
        end else if (dn && !up) begin
            return (y11 + P_STEP >= PY_MAX) ? PY_MAX[9:0] : y + P_STEP[9:0];
        end
        return y;
    endfunction

    always_comb begin
        miss_l = dx_neg_q && (bx <= B_STEP);
        miss_r = !dx_neg_q && (bx + B_STEP >= X_MAX);
        miss   = miss_l || miss_r;
        ov1    = (by + B_SIZE > p1y - P_HALF) && (by <= p1y + P_HALF);
        ov2    = (by + B_SIZE > p2y - P_HALF) && (by <= p2y + P_HALF);
        hit1   = dx_neg_q && ov1 && (bx >= P1_R) && (bx < P1_R + B_STEP);
        hit2   = !dx_neg_q && ov2 && (bx <= P2_FACE) && (bx + B_STEP > P2_FACE);
        win    = miss_l ? (s2_q + 4'd1 == WIN) : (s1_q + 4'd1 == WIN);
        serve_done = (cnt_q == SERVE_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= QI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                QI:     if (start) state_d = QSERVE;
                QSERVE: if (serve_done) state_d = QPLAY;
                QPLAY:  if (miss) state_d = win ? QDONE : QSERVE;
                QDONE:  if (!start) state_d = QI;
                default: state_d = QI;
            endcase
        end
    end

    always_comb begin
        paddles_en = 1'b0;
        play_en    = 1'b0;
        net_en     = 1'b0;
        unique case (state_q)
            QSERVE: begin
                paddles_en = 1'b1;
                net_en     = 1'b1;
            end
            QPLAY: begin
                paddles_en = 1'b1;
                play_en    = 1'b1;
                net_en     = 1'b1;
            end
            default: begin
                paddles_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        p1_y_d   = p1_y_q;
        p2_y_d   = p2_y_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        cnt_d    = cnt_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        if (tick) begin
            if (state_q == QI && start) begin
                s1_d     = 4'd0;
                s2_d     = 4'd0;
                ball_x_d = CX[9:0];
                ball_y_d = CY[9:0];
                cnt_d    = '0;
            end
            if (state_q == QSERVE) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (paddles_en) begin
                p1_y_d = paddle_next(p1_y_q, p1_up, p1_dn);
                p2_y_d = paddle_next(p2_y_q, p2_up, p2_dn);
            end
            if (play_en && miss) begin
                if (miss_l && s2_q < WIN) s2_d = s2_q + 4'd1;
                if (miss_r && s1_q < WIN) s1_d = s1_q + 4'd1;
                // The next serve heads toward the player who conceded.
                if (!win) begin
                    ball_x_d = CX[9:0];
                    ball_y_d = CY[9:0];
                    cnt_d    = '0;
                    dx_neg_d = miss_l;
                end
            end else if (play_en) begin
                if (hit1) begin
                    ball_x_d = P1_R[9:0];
                    dx_neg_d = 1'b0;
                end else if (hit2) begin
                    ball_x_d = P2_FACE[9:0];
                    dx_neg_d = 1'b1;
                end else if (dx_neg_q) begin
                    ball_x_d = ball_x_q - B_STEP[9:0];
                end else begin
                    ball_x_d = ball_x_q + B_STEP[9:0];
                end
                if (dy_neg_q) begin
                    if (by <= B_STEP) begin
                        ball_y_d = 10'd0;
                        dy_neg_d = 1'b0;
                    end else begin
                        ball_y_d = ball_y_q - B_STEP[9:0];
                    end
                end else begin
                    if (by + B_STEP >= Y_MAX) begin
                        ball_y_d = Y_MAX[9:0];
                        dy_neg_d = 1'b1;
                    end else begin
                        ball_y_d = ball_y_q + B_STEP[9:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_y_q   <= CY[9:0];
            p2_y_q   <= CY[9:0];
            ball_x_q <= CX[9:0];
            ball_y_q <= CY[9:0];
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            cnt_q    <= '0;
            s1_q     <= 4'd0;
            s2_q     <= 4'd0;
        end else begin
            p1_y_q   <= p1_y_d;
            p2_y_q   <= p2_y_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            cnt_q    <= cnt_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    always_comb begin
        on_p1 = (cx >= P1_L) && (cx < P1_R)
             && (cy + P_HALF >= p1y) && (cy <= p1y + P_HALF);
        on_p2 = (cx >= P2_L) && (cx < P2_R)
             && (cy + P_HALF >= p2y) && (cy <= p2y + P_HALF);
        on_ball = (cx >= bx) && (cx < bx + B_SIZE)
               && (cy >= by) && (cy < by + B_SIZE);
        on_net = net_en && (cx == CX) && counter_y[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r_q <= 1'b0;
            vga_g_q <= 1'b0;
            vga_b_q <= 1'b0;
        end else begin
            vga_r_q <= in_display && (on_p1 || on_p2);
            vga_g_q <= in_display && on_ball;
            vga_b_q <= in_display && on_net;
        end
    end

    assign vga_r    = vga_r_q;
    assign vga_g    = vga_g_q;
    assign vga_b    = vga_b_q;
    assign p1_score = s1_q;
    assign p2_score = s2_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomised scoreboard bench for pong_game_engine against an
// integer-arithmetic model of the game rules.
module tb_pong_game_engine;

    localparam int H = 640, V = 480, P1X = 32, P2X = 600, PW = 8;
    localparam int PH = 20, PS = 2, BS = 8, BST = 1, SERVE = 64, WIN = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, tick = 1'b0, start = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [9:0] counter_x = '0, counter_y = '0;
    logic       in_display = 1'b0;
    logic       vga_r, vga_g, vga_b;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;

    pong_game_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .counter_x(counter_x), .counter_y(counter_y),
        .in_display(in_display),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .p1_score(p1_score), .p2_score(p2_score), .state(state)
    );

    typedef struct packed {
        logic       r, g, b;
        logic [1:0] st;
        logic [3:0] s1, s2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int compared = 0, mismatched = 0;

    // Model state: st 0 idle, 1 serve, 2 play, 3 done; dx/dy are +1 or -1.
    int m_st, m_s1, m_s2, m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_cnt;
    bit awake1 = 1, awake2 = 1, seen_done = 0;

    task automatic model_reset();
        m_st = 0; m_s1 = 0; m_s2 = 0;
        m_p1y = V / 2; m_p2y = V / 2;
        m_bx = H / 2; m_by = V / 2;
        m_dx = 1; m_dy = 1; m_cnt = 0;
    endtask

    function automatic bit overlap(int py);
        return (m_by + BS > py - PH) && (m_by <= py + PH);
    endfunction

    function automatic int move(int y, bit u, bit d);
        if (u && !d) return (y - PS < PH) ? PH : y - PS;
        if (d && !u) return (y + PS > V - 1 - PH) ? V - 1 - PH : y + PS;
        return y;
    endfunction

    task automatic model_tick(input bit st_in, input bit u1, d1, u2, d2);
        int  old_st, nx, ny, scorer;
        bit  ov1, ov2;
        old_st = m_st;
        ov1 = overlap(m_p1y);
        ov2 = overlap(m_p2y);
        case (m_st)
            0: if (st_in) begin
                m_st = 1; m_s1 = 0; m_s2 = 0;
                m_bx = H / 2; m_by = V / 2; m_cnt = 0;
            end
            1: begin
                m_cnt++;
                if (m_cnt == SERVE) m_st = 2;
            end
            2: begin
                nx = m_bx + m_dx * BST;
                ny = m_by + m_dy * BST;
                scorer = 0;
                if (nx <= 0) scorer = 2;
                else if (nx >= H - BS) scorer = 1;
                if (scorer != 0) begin
                    if (scorer == 2) m_s2++; else m_s1++;
                    if ((scorer == 2 ? m_s2 : m_s1) == WIN) begin
                        m_st = 3;
                    end else begin
                        m_st = 1; m_cnt = 0;
                        m_bx = H / 2; m_by = V / 2;
                        m_dx = (scorer == 2) ? -1 : 1;
                    end
                end else begin
                    if (m_dx < 0 && m_bx >= P1X + PW && nx < P1X + PW && ov1) begin
                        m_bx = P1X + PW; m_dx = 1;
                    end else if (m_dx > 0 && m_bx <= P2X - BS && nx > P2X - BS && ov2) begin
                        m_bx = P2X - BS; m_dx = -1;
                    end else begin
                        m_bx = nx;
                    end
                    if (ny <= 0) begin
                        m_by = 0; m_dy = 1;
                    end else if (ny >= V - BS) begin
                        m_by = V - BS; m_dy = -1;
                    end else begin
                        m_by = ny;
                    end
                end
            end
            default: if (!st_in) m_st = 0;
        endcase
        if (old_st == 1 || old_st == 2) begin
            m_p1y = move(m_p1y, u1, d1);
            m_p2y = move(m_p2y, u2, d2);
        end
        if (m_st == 3) seen_done = 1;
    endtask

    function automatic exp_t pixel(int cx, int cy, bit disp);
        exp_t e;
        e = '0;
        e.r = disp && ((cx >= P1X && cx < P1X + PW && cy >= m_p1y - PH && cy <= m_p1y + PH)
                    || (cx >= P2X && cx < P2X + PW && cy >= m_p2y - PH && cy <= m_p2y + PH));
        e.g = disp && cx >= m_bx && cx < m_bx + BS && cy >= m_by && cy < m_by + BS;
        e.b = disp && (m_st == 1 || m_st == 2) && cx == H / 2 && ((cy / 8) % 2 == 1);
        return e;
    endfunction

    task automatic cycle(input bit rst, tk, st_in, u1, d1, u2, d2);
        exp_t e;
        int   mode, x, y;
        @(negedge clk);
        mode = int'($urandom_range(0, 3));
        case (mode)
            0: begin x = int'($urandom_range(0, 700)); y = int'($urandom_range(0, 520)); end
            1: begin
                x = m_bx + int'($urandom_range(0, 13)) - 3;
                y = m_by + int'($urandom_range(0, 13)) - 3;
            end
            2: begin
                x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(28, 44))
                                                : int'($urandom_range(596, 612));
                y = (x < 100 ? m_p1y : m_p2y) + int'($urandom_range(0, 50)) - 25;
            end
            default: begin x = int'($urandom_range(318, 322)); y = int'($urandom_range(0, 479)); end
        endcase
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        reset = rst; tick = tk; start = st_in;
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        counter_x = 10'(x); counter_y = 10'(y);
        in_display = ($urandom_range(0, 7) != 0);
        e = rst ? '0 : pixel(x, y, in_display);
        if (rst) model_reset();
        else if (tk) model_tick(st_in, u1, d1, u2, d2);
        e.st = 2'(m_st);
        e.s1 = 4'(m_s1);
        e.s2 = 4'(m_s2);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("vga_r", int'(vga_r), int'(mon_e.r));
            chk("vga_g", int'(vga_g), int'(mon_e.g));
            chk("vga_b", int'(vga_b), int'(mon_e.b));
            chk("state", int'(state), int'(mon_e.st));
            chk("p1_score", int'(p1_score), int'(mon_e.s1));
            chk("p2_score", int'(p2_score), int'(mon_e.s2));
        end
    end

    task automatic play_buttons(output bit u1, d1, u2, d2);
        int target;
        target = m_by + BS / 2;
        if (awake1) begin
            u1 = m_p1y > target + 2; d1 = m_p1y < target - 2;
        end else begin
            u1 = $urandom_range(0, 1) == 1; d1 = $urandom_range(0, 1) == 1;
        end
        if (awake2) begin
            u2 = m_p2y > target + 2; d2 = m_p2y < target - 2;
        end else begin
            u2 = $urandom_range(0, 1) == 1; d2 = $urandom_range(0, 1) == 1;
        end
    endtask

    initial begin
        bit u1, d1, u2, d2, tk, st_in, rst;
        int waited;
        model_reset();
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (5) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        repeat (270) cycle(0, 1, 0, 1, 0, 0, 1);
        repeat (20) cycle(0, 1, 0, 1, 1, 1, 1);
        repeat (30) cycle(0, 0, 0, 1, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        for (int n = 0; n < 60000; n++) begin
            if (mismatched > 100) break;
            if (seen_done && m_st == 0) break;
            tk = ($urandom_range(0, 7) != 0);
            st_in = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 19999) == 0);
            if (tk && $urandom_range(0, 599) == 0) begin
                awake1 = ($urandom_range(0, 2) != 0);
                awake2 = ($urandom_range(0, 2) != 0);
            end
            play_buttons(u1, d1, u2, d2);
            cycle(rst, tk, st_in, u1, d1, u2, d2);
        end
        cycle(0, 1, 1, 0, 0, 0, 0);
        repeat (4) cycle(0, 1, 0, 0, 0, 0, 0);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
